// File: rtl/washer_drop_sequencer.sv
// Washer pick/drop sequencer: walks the servo and electromagnet through a timed
// lower/grab/raise/hold/release cycle and checks the washer sensor after the raise.
module washer_drop_sequencer #(
  parameter int unsigned LOWER_CYC   = 32'd50_000_000,
  parameter int unsigned GRAB_CYC    = 32'd20_000_000,
  parameter int unsigned RAISE_CYC   = 32'd50_000_000,
  parameter int unsigned RELEASE_CYC = 32'd20_000_000,
  parameter int unsigned TW          = 32'd32
) (
  input  logic CLK,
  input  logic RST,
  input  logic start,
  input  logic release_cmd,
  input  logic abort,
  input  logic clear_fault,
  input  logic washer_present,
  output logic servo_down,
  output logic magnet_en,
  output logic busy,
  output logic holding,
  output logic done,
  output logic fault
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOWER   = 3'd1,
    S_GRAB    = 3'd2,
    S_RAISE   = 3'd3,
    S_HOLD    = 3'd4,
    S_RELEASE = 3'd5,
    S_FAULT   = 3'd6
  } state_t;

  // A timed state with length N leaves when the timer reads N-1.
  localparam logic [TW-1:0] L_LOWER_END   = TW'(LOWER_CYC   - 32'd1);
  localparam logic [TW-1:0] L_GRAB_END    = TW'(GRAB_CYC    - 32'd1);
  localparam logic [TW-1:0] L_RAISE_END   = TW'(RAISE_CYC   - 32'd1);
  localparam logic [TW-1:0] L_RELEASE_END = TW'(RELEASE_CYC - 32'd1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_timer;
  logic          r_aborted;
  logic          w_aborted_nxt;
  logic          w_done_evt;
  logic          r_done_evt;
  logic          w_timed;
  logic          w_timer_end;

  logic          w_servo_down;
  logic          w_magnet_en;
  logic          w_busy;
  logic          w_holding;
  logic          w_fault;
  logic          r_servo_down;
  logic          r_magnet_en;
  logic          r_busy;
  logic          r_holding;
  logic          r_done;
  logic          r_fault;

  // Timer terminal-count decode for the current state.
  always_comb begin
    w_timed     = 1'b1;
    w_timer_end = 1'b0;
    case (r_state)
      S_LOWER:   w_timer_end = (r_timer == L_LOWER_END);
      S_GRAB:    w_timer_end = (r_timer == L_GRAB_END);
      S_RAISE:   w_timer_end = (r_timer == L_RAISE_END);
      S_RELEASE: w_timer_end = (r_timer == L_RELEASE_END);
      default:   w_timed     = 1'b0;
    endcase
  end

  // Next-state logic; abort outranks every other request in the active states.
  always_comb begin
    w_state_nxt   = r_state;
    w_aborted_nxt = r_aborted;
    w_done_evt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt   = S_LOWER;
          w_aborted_nxt = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOWER: begin
        if (abort) begin
          w_state_nxt   = S_RELEASE;
          w_aborted_nxt = 1'b1;
        end else if (w_timer_end) begin
          w_state_nxt = S_GRAB;
        end else begin
          w_state_nxt = S_LOWER;
        end
      end
      S_GRAB: begin
        if (abort) begin
          w_state_nxt   = S_RELEASE;
          w_aborted_nxt = 1'b1;
        end else if (w_timer_end) begin
          w_state_nxt = S_RAISE;
        end else begin
          w_state_nxt = S_GRAB;
        end
      end
      S_RAISE: begin
        if (abort) begin
          w_state_nxt   = S_RELEASE;
          w_aborted_nxt = 1'b1;
        end else if (w_timer_end) begin
          if (washer_present) begin
            w_state_nxt = S_HOLD;
          end else begin
            w_state_nxt = S_FAULT;
          end
        end else begin
          w_state_nxt = S_RAISE;
        end
      end
      S_HOLD: begin
        if (abort) begin
          w_state_nxt   = S_RELEASE;
          w_aborted_nxt = 1'b1;
        end else if (release_cmd) begin
          w_state_nxt   = S_RELEASE;
          w_aborted_nxt = 1'b0;
        end else if (!washer_present) begin
          w_state_nxt = S_FAULT;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      S_RELEASE: begin
        if (w_timer_end) begin
          w_state_nxt   = S_IDLE;
          w_done_evt    = !r_aborted;
          w_aborted_nxt = 1'b0;
        end else begin
          w_state_nxt = S_RELEASE;
        end
      end
      S_FAULT: begin
        if (clear_fault) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_FAULT;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_aborted_nxt = 1'b0;
      end
    endcase
  end

  // State, timer and completion-event registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_timer    <= {TW{1'b0}};
      r_aborted  <= 1'b0;
      r_done_evt <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_aborted  <= w_aborted_nxt;
      r_done_evt <= w_done_evt;
      if ((w_state_nxt != r_state) || !w_timed) begin
        r_timer <= {TW{1'b0}};
      end else begin
        r_timer <= r_timer + TW'(1);
      end
    end
  end

  // Moore output decode of the current state.
  always_comb begin
    w_servo_down = 1'b0;
    w_magnet_en  = 1'b0;
    w_busy       = 1'b1;
    w_holding    = 1'b0;
    w_fault      = 1'b0;
    case (r_state)
      S_IDLE:    w_busy = 1'b0;
      S_LOWER:   w_servo_down = 1'b1;
      S_GRAB: begin
        w_servo_down = 1'b1;
        w_magnet_en  = 1'b1;
      end
      S_RAISE:   w_magnet_en = 1'b1;
      S_HOLD: begin
        w_magnet_en = 1'b1;
        w_holding   = 1'b1;
      end
      S_RELEASE: w_busy = 1'b1;
      S_FAULT: begin
        w_busy  = 1'b0;
        w_fault = 1'b1;
      end
      default:   w_busy = 1'b0;
    endcase
  end

  // Output registers; reset drops the magnet and raises the servo on the first edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_servo_down <= 1'b0;
      r_magnet_en  <= 1'b0;
      r_busy       <= 1'b0;
      r_holding    <= 1'b0;
      r_done       <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_servo_down <= w_servo_down;
      r_magnet_en  <= w_magnet_en;
      r_busy       <= w_busy;
      r_holding    <= w_holding;
      r_done       <= r_done_evt;
      r_fault      <= w_fault;
    end
  end

  assign servo_down = r_servo_down;
  assign magnet_en  = r_magnet_en;
  assign busy       = r_busy;
  assign holding    = r_holding;
  assign done       = r_done;
  assign fault      = r_fault;

endmodule

// File: tb/tb_washer_drop_sequencer.sv
// Directed bench for washer_drop_sequencer with short timed-state lengths:
// a table of {inputs, repeat count, expected outputs} plus hand-written timing checks.
module tb_washer_drop_sequencer;

  logic CLK = 1'b0;
  logic RST, start, release_cmd, abort, clear_fault, washer_present;
  logic servo_down, magnet_en, busy, holding, done, fault;
  logic [5:0] outs;

  int n_total = 0;
  int n_pass  = 0;

  // Input bits: {RST, start, release_cmd, abort, clear_fault, washer_present}
  localparam logic [5:0] I_NONE = 6'b000000;
  localparam logic [5:0] I_RST  = 6'b100000;
  localparam logic [5:0] I_STA  = 6'b010000;
  localparam logic [5:0] I_REL  = 6'b001000;
  localparam logic [5:0] I_ABT  = 6'b000100;
  localparam logic [5:0] I_CLR  = 6'b000010;
  localparam logic [5:0] I_WP   = 6'b000001;
  // Output bits: {servo_down, magnet_en, busy, holding, done, fault}
  localparam logic [5:0] O_IDLE = 6'b000000;
  localparam logic [5:0] O_LOW  = 6'b101000;
  localparam logic [5:0] O_GRB  = 6'b111000;
  localparam logic [5:0] O_RAI  = 6'b011000;
  localparam logic [5:0] O_HLD  = 6'b011100;
  localparam logic [5:0] O_REL  = 6'b001000;
  localparam logic [5:0] O_DON  = 6'b000010;
  localparam logic [5:0] O_FLT  = 6'b000001;

  typedef struct {
    int unsigned n;
    logic [5:0]  in;
    logic [5:0]  exp;
  } vec_t;

  vec_t vecs[$];

  washer_drop_sequencer #(
    .LOWER_CYC(32'd4), .GRAB_CYC(32'd3), .RAISE_CYC(32'd5), .RELEASE_CYC(32'd2), .TW(32'd32)
  ) dut (
    .CLK(CLK), .RST(RST), .start(start), .release_cmd(release_cmd), .abort(abort),
    .clear_fault(clear_fault), .washer_present(washer_present),
    .servo_down(servo_down), .magnet_en(magnet_en), .busy(busy), .holding(holding),
    .done(done), .fault(fault)
  );

  assign outs = {servo_down, magnet_en, busy, holding, done, fault};

  always #5 CLK = ~CLK;

  function automatic vec_t mk(input int unsigned n, input logic [5:0] i, input logic [5:0] e);
    vec_t r;
    r.n   = n;
    r.in  = i;
    r.exp = e;
    return r;
  endfunction

  task automatic drive(input logic [5:0] i);
    RST            = i[5];
    start          = i[4];
    release_cmd    = i[3];
    abort          = i[2];
    clear_fault    = i[1];
    washer_present = i[0];
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic check_vec(input int idx, input int rep, input logic [5:0] got, input logic [5:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL vec%0d.%0d outputs {sd,mg,bz,hd,dn,ft}: got %b expected %b", idx, rep, got, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_sd_on, t_sd_off, t_mg_on, t_hd_on;
    int off_cnt, done_seen, busy_at_done;

    // Reset, then reset asserted in the second GRAB cycle.
    vecs.push_back(mk(2, I_RST | I_WP, O_IDLE));
    vecs.push_back(mk(2, I_WP, O_IDLE));
    vecs.push_back(mk(1, I_STA | I_WP, O_IDLE));
    vecs.push_back(mk(4, I_WP, O_LOW));
    vecs.push_back(mk(1, I_WP, O_GRB));
    vecs.push_back(mk(3, I_RST | I_WP, O_IDLE));
    vecs.push_back(mk(2, I_WP, O_IDLE));
    // Normal cycle with release from HOLD.
    vecs.push_back(mk(1, I_STA | I_WP, O_IDLE));
    vecs.push_back(mk(4, I_WP, O_LOW));
    vecs.push_back(mk(3, I_WP, O_GRB));
    vecs.push_back(mk(5, I_WP, O_RAI));
    vecs.push_back(mk(3, I_WP, O_HLD));
    vecs.push_back(mk(1, I_REL | I_WP, O_HLD));
    vecs.push_back(mk(2, I_WP, O_REL));
    vecs.push_back(mk(1, I_WP, O_DON));
    vecs.push_back(mk(2, I_WP, O_IDLE));
    // Abort/release/clear in IDLE do nothing.
    vecs.push_back(mk(1, I_ABT | I_REL | I_CLR | I_WP, O_IDLE));
    vecs.push_back(mk(1, I_WP, O_IDLE));
    // No washer at end of RAISE: fault, start and abort ignored, clear_fault exits.
    vecs.push_back(mk(1, I_STA, O_IDLE));
    vecs.push_back(mk(4, I_NONE, O_LOW));
    vecs.push_back(mk(3, I_NONE, O_GRB));
    vecs.push_back(mk(5, I_NONE, O_RAI));
    vecs.push_back(mk(1, I_NONE, O_FLT));
    vecs.push_back(mk(2, I_STA, O_FLT));
    vecs.push_back(mk(1, I_ABT, O_FLT));
    vecs.push_back(mk(1, I_CLR, O_FLT));
    vecs.push_back(mk(2, I_WP, O_IDLE));
    // Abort in the second GRAB cycle: release without done.
    vecs.push_back(mk(1, I_STA | I_WP, O_IDLE));
    vecs.push_back(mk(4, I_WP, O_LOW));
    vecs.push_back(mk(1, I_WP, O_GRB));
    vecs.push_back(mk(1, I_ABT | I_WP, O_GRB));
    vecs.push_back(mk(2, I_WP, O_REL));
    vecs.push_back(mk(2, I_WP, O_IDLE));
    // Abort together with release_cmd in HOLD: abort wins, no done.
    vecs.push_back(mk(1, I_STA | I_WP, O_IDLE));
    vecs.push_back(mk(4, I_WP, O_LOW));
    vecs.push_back(mk(3, I_WP, O_GRB));
    vecs.push_back(mk(5, I_WP, O_RAI));
    vecs.push_back(mk(1, I_WP, O_HLD));
    vecs.push_back(mk(1, I_ABT | I_REL | I_WP, O_HLD));
    vecs.push_back(mk(2, I_WP, O_REL));
    vecs.push_back(mk(2, I_WP, O_IDLE));
    // Washer lost while holding: fault.
    vecs.push_back(mk(1, I_STA | I_WP, O_IDLE));
    vecs.push_back(mk(4, I_WP, O_LOW));
    vecs.push_back(mk(3, I_WP, O_GRB));
    vecs.push_back(mk(5, I_WP, O_RAI));
    vecs.push_back(mk(2, I_WP, O_HLD));
    vecs.push_back(mk(1, I_NONE, O_HLD));
    vecs.push_back(mk(1, I_WP, O_FLT));
    vecs.push_back(mk(1, I_CLR | I_WP, O_FLT));
    vecs.push_back(mk(1, I_WP, O_IDLE));
    // Start held high throughout: ignored while busy, back-to-back cycle after done.
    vecs.push_back(mk(1, I_STA | I_WP, O_IDLE));
    vecs.push_back(mk(4, I_STA | I_WP, O_LOW));
    vecs.push_back(mk(3, I_STA | I_WP, O_GRB));
    vecs.push_back(mk(5, I_STA | I_WP, O_RAI));
    vecs.push_back(mk(1, I_STA | I_WP, O_HLD));
    vecs.push_back(mk(1, I_STA | I_REL | I_WP, O_HLD));
    vecs.push_back(mk(2, I_STA | I_WP, O_REL));
    vecs.push_back(mk(1, I_STA | I_WP, O_DON));
    vecs.push_back(mk(4, I_WP, O_LOW));
    vecs.push_back(mk(1, I_ABT | I_WP, O_GRB));
    vecs.push_back(mk(2, I_WP, O_REL));
    vecs.push_back(mk(2, I_WP, O_IDLE));

    drive(I_RST | I_WP);
    @(negedge CLK);
    foreach (vecs[i]) begin
      for (int k = 0; k < int'(vecs[i].n); k++) begin
        drive(vecs[i].in);
        @(posedge CLK);
        #1;
        check_vec(i, k, outs, vecs[i].exp);
      end
    end

    // Timing of one pick cycle measured from the start edge.
    drive(I_STA | I_WP);
    @(posedge CLK);
    #1;
    drive(I_WP);
    check("start_edge_busy", int'(busy), 0);
    t_sd_on = -1; t_sd_off = -1; t_mg_on = -1; t_hd_on = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge CLK);
      #1;
      if (servo_down && t_sd_on < 0) t_sd_on = k;
      if (!servo_down && t_sd_on >= 0 && t_sd_off < 0) t_sd_off = k;
      if (magnet_en && t_mg_on < 0) t_mg_on = k;
      if (holding && t_hd_on < 0) t_hd_on = k;
    end
    check("servo_down_first_cycle", t_sd_on, 1);
    check("servo_down_length", t_sd_off - t_sd_on, 7);
    check("magnet_after_servo", t_mg_on - t_sd_on, 4);
    check("holding_after_servo", t_hd_on - t_sd_on, 12);
    check("still_holding", int'(holding), 1);

    // Release from HOLD: magnet off while busy for RELEASE cycles, done with busy low.
    drive(I_REL | I_WP);
    @(posedge CLK);
    #1;
    drive(I_WP);
    off_cnt = 0; done_seen = 0; busy_at_done = 1;
    for (int k = 0; k < 10 && done_seen == 0; k++) begin
      @(posedge CLK);
      #1;
      if (busy && !magnet_en) off_cnt++;
      if (done) begin
        done_seen    = 1;
        busy_at_done = int'(busy);
      end
    end
    check("release_magnet_off_cycles", off_cnt, 2);
    check("done_seen", done_seen, 1);
    check("busy_at_done", busy_at_done, 0);
    @(posedge CLK);
    #1;
    check("done_single_pulse", int'(done), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
